sqrt_sched: RTL and testbench

- Shared iterative Q16.16 square-root engine with round-robin arbitration between N requesters.
- Performs one bisection step per clock and returns the floor square root, tagged with the requester ID.
- Replaces per-client combinational square-root instances in the training datapath.
- Sits between client request ports and a single downstream response consumer.

---
 rtl/sqrt_pkg.sv | 26 ++
 rtl/sqrt_step.sv | 48 ++++
 rtl/sqrt_sched.sv | 159 +++++++++++++++
 tb/tb_sqrt_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the Q16.16 square-root scheduler.
// No logic; definitions only.
// No flow control of its own.
package sqrt_pkg;

  localparam int Q_W    = 32;  // total Q16.16 width
  localparam int Q_FRAC = 16;  // fractional bits

  localparam logic [Q_W-1:0] FIXED_ONE = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result of one bisection step: the narrowed bracket plus termination info.
  typedef struct packed {
    logic [Q_W-1:0] low;
    logic [Q_W-1:0] high;
    logic           done;   // exact hit or bracket closed to width 1
    logic           exact;  // (mid*mid)>>16 == x
    logic [Q_W-1:0] root;   // mid on an exact hit, otherwise the new low
  } step_t;

endpackage

// File: rtl/sqrt_step.sv
// One combinational bisection step of the Q16.16 floor-sqrt search.
// Zero latency: outputs depend only on the current bracket and operand.
// No flow control; the caller decides when to register the result.
module sqrt_step
  import sqrt_pkg::*;
(
  input  logic [Q_W-1:0] low_i,
  input  logic [Q_W-1:0] high_i,
  input  logic [Q_W-1:0] x_i,
  output step_t          step_o
);

  logic [Q_W:0]     sum;        // 33 bits so 0xFFFF_FFFF + 0xFFFF_FFFF cannot wrap
  logic [Q_W-1:0]   mid;
  logic [2*Q_W-1:0] prod;
  logic [2*Q_W-1:0] x_lo;       // x<<16: smallest product whose >>16 equals x
  logic [2*Q_W-1:0] x_hi;       // (x+1)<<16: first product whose >>16 exceeds x
  logic             sq_lt;
  logic             sq_eq;
  logic [Q_W-1:0]   low_n;
  logic [Q_W-1:0]   high_n;
  logic             unused_sum_lsb;

  assign sum            = {1'b0, low_i} + {1'b0, high_i};
  assign mid            = sum[Q_W:1];
  assign unused_sum_lsb = sum[0];
  assign prod           = {{Q_W{1'b0}}, mid} * {{Q_W{1'b0}}, mid};

  // Compare the full product against x scaled up, so no product bits are dropped.
  assign x_lo  = {{(Q_W-Q_FRAC){1'b0}}, x_i, {Q_FRAC{1'b0}}};
  assign x_hi  = x_lo + (64'd1 << Q_FRAC);
  assign sq_lt = (prod < x_lo);
  assign sq_eq = !sq_lt && (prod < x_hi);

  assign low_n  = sq_lt ? mid : low_i;
  assign high_n = sq_lt ? high_i : mid;

  // Pack the narrowed bracket and termination flags for the scheduler.
  always_comb begin
    step_o       = '0;
    step_o.low   = low_n;
    step_o.high  = high_n;
    step_o.exact = sq_eq;
    step_o.done  = sq_eq || ((high_n - low_n) <= 32'd1);
    step_o.root  = sq_eq ? mid : low_n;
  end

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin shared Q16.16 floor-sqrt engine, one bisection step per clock.
// Latency: response valid k+1 cycles after the grant (k = steps), 1 for x=0 or 1.0.
// One operation in flight; result held until rsp_ready, no grants meanwhile.
module sqrt_sched
  import sqrt_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_ITER = 34,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*Q_W-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [Q_W-1:0]         rsp_root,
  output logic                   rsp_exact,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MAX_ITER);

  state_t           state_q,  state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q,     id_d;
  logic [Q_W-1:0]   x_q,      x_d;
  logic [Q_W-1:0]   low_q,    low_d;
  logic [Q_W-1:0]   high_q,   high_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [Q_W-1:0]   root_q,   root_d;
  logic             exact_q,  exact_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [Q_W-1:0]   grant_x;
  logic             found;
  step_t            step;

  sqrt_step u_step (
    .low_i  (low_q),
    .high_i (high_q),
    .x_i    (x_q),
    .step_o (step)
  );

  // Round-robin pick: first valid at or after rr_ptr, else wrap to the lowest valid.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    grant_x  = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
        grant_x  = req_x[Q_W*i +: Q_W];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
        grant_x  = req_x[Q_W*i +: Q_W];
      end
    end
  end

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_root  = root_q;
  assign rsp_exact = exact_q;
  assign busy      = (state_q != IDLE);

  // Next-state: accept in IDLE, iterate in CALC, hold the result in DONE.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    x_d      = x_q;
    low_d    = low_q;
    high_d   = high_q;
    cnt_d    = cnt_q;
    root_d   = root_q;
    exact_d  = exact_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d = grant_id;
          x_d  = grant_x;
          if (grant_x == '0) begin
            root_d  = '0;
            exact_d = 1'b1;
            state_d = DONE;
          end else if (grant_x == FIXED_ONE) begin
            root_d  = grant_x;
            exact_d = 1'b1;
            state_d = DONE;
          end else begin
            // high starts where high*high>>16 is already above x
            low_d   = '0;
            high_d  = (grant_x > FIXED_ONE) ? grant_x : FIXED_ONE;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        low_d  = step.low;
        high_d = step.high;
        if (step.done || (cnt_q == CNT_W'(MAX_ITER - 1))) begin
          root_d  = step.root;
          exact_d = step.exact;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      low_q    <= '0;
      high_q   <= '0;
      cnt_q    <= '0;
      root_q   <= '0;
      exact_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      low_q    <= low_d;
      high_q   <= high_d;
      cnt_q    <= cnt_d;
      root_q   <= root_d;
      exact_q  <= exact_d;
    end
  end

endmodule

// File: tb/tb_sqrt_sched.sv
// Bench for sqrt_sched: directed cases plus random traffic against a reference model.
// Reference computes floor sqrt digit-by-digit and round-robin order from a pointer.
// Consumer backpressure is exercised with random hold cycles.
module tb_sqrt_sched;

  localparam int          NR  = 4;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] req_x;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_root;
  logic            rsp_exact;
  logic            busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ptr     = 0;   // model round-robin pointer
  logic [31:0] xs [NR];
  logic [3:0]  glitch  = 4'b0000;

  sqrt_sched #(.N_REQ(NR), .MAX_ITER(34)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_root  (rsp_root),
    .rsp_exact (rsp_exact),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Largest r with (r*r)>>16 <= x, i.e. r*r < (x+1)<<16; x==0 is defined as root 0.
  function automatic logic [31:0] ref_root(input logic [31:0] x);
    longint unsigned n, r, t;
    if (x == 32'd0) return 32'd0;
    n = {16'h0, x, 16'hFFFF};
    r = 0;
    for (int b = 23; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    return 32'(r);
  endfunction

  function automatic logic ref_exact(input logic [31:0] x, input logic [31:0] r);
    longint unsigned p;
    if (x == 32'd0) return 1'b1;
    p = {32'h0, r} * {32'h0, r};
    return (p >> 16) == {32'h0, x};
  endfunction

  task automatic load_x();
    for (int i = 0; i < NR; i++) req_x[32*i +: 32] = xs[i];
  endtask

  // Present mask, check the grant, wait for the result, check it, hold, then accept.
  task automatic do_op(input logic [3:0] mask, input int hold, input int exp_lat);
    int          gid;
    int          lat;
    logic [31:0] xv;
    logic [31:0] er;
    logic        ee;
    gid = 0;
    for (int k = NR - 1; k >= 0; k--) begin
      if (mask[(ptr + k) % NR]) gid = (ptr + k) % NR;
    end
    req_valid = mask;
    load_x();
    rsp_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("grant", req_ready, 64'(1 << gid));
    xv = xs[gid];
    er = ref_root(xv);
    ee = ref_exact(xv, er);
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid[gid] = 1'b0;
        chk("ready_low", req_ready, 0);
      end
      if (lat == 2) req_valid = req_valid | glitch;
      if (lat == 3) req_valid = req_valid & ~glitch;
    end while (!rsp_valid && lat < 100);
    chk("rsp_valid", rsp_valid, 1);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    if (xv == 32'd0 || xv == ONE) chk("special_lat", lat, 1);
    chk("rsp_id", rsp_id, gid);
    chk("rsp_root", rsp_root, er);
    chk("rsp_exact", rsp_exact, ee);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_root", rsp_root, er);
      chk("hold_id", rsp_id, gid);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    ptr = (gid + 1) % NR;
    chk("rsp_drop", rsp_valid, 0);
    chk("back_idle", busy, 0);
  endtask

  function automatic logic [31:0] gen_x();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'd0;
      1:       v = ONE;
      2:       v = 32'hFFFF_FFFF;
      3, 4:    v = $urandom_range(32'h4000, 32'h0010_0000);
      default: v = $urandom;
    endcase
    // below 0x4000 several roots map to the same x, so keep random operands above it
    if (v != 32'd0 && v < 32'h4000) v = v | 32'h4000;
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) xs[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_root", rsp_root, 0);
    chk("rst_rsp_exact", rsp_exact, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed operands
    xs[0] = 32'h0004_0000; do_op(4'b0001, 0, 2);
    xs[1] = 32'h0002_0000; do_op(4'b0010, 0, 0);
    xs[2] = 32'h0000_4000; do_op(4'b0100, 0, 0);
    xs[3] = 32'h0000_0000; do_op(4'b1000, 0, 1);
    xs[0] = 32'hFFFF_FFFF; do_op(4'b0001, 0, 0);
    xs[1] = ONE;           do_op(4'b0010, 0, 1);
    xs[3] = 32'h0009_0000; do_op(4'b1000, 0, 0);

    // simultaneous requesters
    xs[0] = 32'h0003_0000; xs[2] = 32'h0019_0000;
    do_op(4'b0101, 0, 0);
    do_op(4'b0101, 0, 0);
    do_op(4'b0101, 0, 0);

    // long backpressure
    xs[1] = 32'h1234_5678; do_op(4'b0010, 10, 0);

    // requester 3 pulses valid while busy and must not be remembered
    glitch = 4'b1000;
    xs[2] = 32'h1234_5678; do_op(4'b0100, 0, 0);
    glitch = 4'b0000;
    xs[0] = 32'h0000_9000; xs[1] = 32'h0007_0000; do_op(4'b0011, 0, 0);

    // reset in the middle of a computation
    xs[1] = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    load_x();
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("calc_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_root", rsp_root, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    for (int i = 0; i < NR; i++) xs[i] = 32'h0000_0000 + 32'((i + 2) * (i + 2)) * ONE;
    do_op(4'b1111, 0, 0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++) xs[i] = gen_x();
      do_op(4'($urandom_range(1, 15)), $urandom_range(0, 3), 0);
    end

    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
